// File: rtl/vga_hello_pkg.sv
// Shared constants for the VGA "HELLO WORLD" tile: 640x480@60 timing, text placement,
// the message string and the 5x7 glyph ROM.
package vga_hello_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_LAST       = 10'd524;

  // Text box: 11 cells of 8x8 font pixels, each font pixel drawn 4x4.
  localparam logic [9:0] TEXT_X0    = 10'd144;
  localparam logic [9:0] TEXT_Y0    = 10'd224;
  localparam logic [9:0] TEXT_X1    = 10'd496;
  localparam logic [9:0] TEXT_Y1    = 10'd256;
  localparam int unsigned TEXT_SCALE = 4;

  typedef enum logic [2:0] {
    CH_SPACE = 3'd0,
    CH_H     = 3'd1,
    CH_E     = 3'd2,
    CH_L     = 3'd3,
    CH_O     = 3'd4,
    CH_W     = 3'd5,
    CH_R     = 3'd6,
    CH_D     = 3'd7
  } char_code_e;

  function automatic char_code_e text_char(input logic [3:0] idx);
    char_code_e c;
    case (idx)
      4'd0:    c = CH_H;
      4'd1:    c = CH_E;
      4'd2:    c = CH_L;
      4'd3:    c = CH_L;
      4'd4:    c = CH_O;
      4'd5:    c = CH_SPACE;
      4'd6:    c = CH_W;
      4'd7:    c = CH_O;
      4'd8:    c = CH_R;
      4'd9:    c = CH_L;
      4'd10:   c = CH_D;
      default: c = CH_SPACE;
    endcase
    return c;
  endfunction

  // Returns the 5-bit row pattern, MSB = leftmost column; row 7 is the blank spacer row.
  function automatic logic [4:0] glyph_row(input char_code_e code, input logic [2:0] row);
    logic [34:0] g;
    logic [5:0]  base;
    case (code)
      CH_H:    g = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      CH_E:    g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      CH_L:    g = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      CH_O:    g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      CH_W:    g = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      CH_R:    g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
      CH_D:    g = {5'h1E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1E};
      default: g = 35'h0;
    endcase
    base = 6'(3'd6 - row) * 6'd5;
    if (row < 3'd7) begin
      return g[base +: 5];
    end else begin
      return 5'h00;
    end
  endfunction

endpackage

// File: rtl/vga_hello_if.sv
// Raster position bus from the timing generator to the pixel pipeline.
interface vga_hello_if;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       hsync;
  logic       vsync;
  logic       visible;

  modport master (output hcnt, vcnt, hsync, vsync, visible);
  modport slave  (input  hcnt, vcnt, hsync, vsync, visible);
endinterface

// File: rtl/vga_timing.sv
// 800x525 raster counters with raw (unregistered) active-low syncs and visible flag.
module vga_timing
  import vga_hello_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  vga_hello_if.master  tim
);

  logic [9:0] hcnt_r;
  logic [9:0] vcnt_r;

  // Pixel and line counters; the line advances when the pixel counter wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= 10'd0;
      vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : vcnt_r + 10'd1;
    end else begin
      hcnt_r <= hcnt_r + 10'd1;
      vcnt_r <= vcnt_r;
    end
  end

  assign tim.hcnt    = hcnt_r;
  assign tim.vcnt    = vcnt_r;
  assign tim.hsync   = !((hcnt_r >= H_SYNC_START) && (hcnt_r < H_SYNC_END));
  assign tim.vsync   = !((vcnt_r >= V_SYNC_START) && (vcnt_r < V_SYNC_END));
  assign tim.visible = (hcnt_r < H_VISIBLE) && (vcnt_r < V_VISIBLE);

endmodule

// File: rtl/tt_um_vga_hello_world.sv
// Tiny Tapeout tile drawing "HELLO WORLD" on a TinyVGA PMOD; outputs registered one pixel late.
// Optional build macro COLOR_CYCLE_EN cycles the text colour with a frame counter.
module tt_um_vga_hello_world
  import vga_hello_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  vga_hello_if tim_if ();

  vga_timing u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .tim   (tim_if.master)
  );

  logic [9:0] tx_s;
  logic [9:0] ty_s;
  logic       in_box_s;
  logic [2:0] col_s;
  logic [2:0] row_s;
  logic [4:0] glyph_s;
  logic [7:0] glyph_pad_s;
  logic       lit_s;
  logic [5:0] text_rgb_s;
  logic [5:0] fg_rgb_s;
  logic [5:0] bg_rgb_s;
  logic [5:0] pix_rgb_s;
  logic [7:0] uo_next_s;
  logic [7:0] uo_r;

  assign tx_s     = tim_if.hcnt - TEXT_X0;
  assign ty_s     = tim_if.vcnt - TEXT_Y0;
  assign in_box_s = (tim_if.hcnt >= TEXT_X0) && (tim_if.hcnt < TEXT_X1) &&
                    (tim_if.vcnt >= TEXT_Y0) && (tim_if.vcnt < TEXT_Y1);
  assign col_s    = tx_s[4:2];
  assign row_s    = ty_s[4:2];
  assign glyph_s  = glyph_row(text_char(tx_s[8:5]), row_s);
  // Bit-reversed and padded so the column number indexes it directly.
  assign glyph_pad_s = {3'b000, glyph_s[0], glyph_s[1], glyph_s[2], glyph_s[3], glyph_s[4]};

`ifdef COLOR_CYCLE_EN
  logic [7:0] frame_r;

  // Frame counter advancing on the last pixel of each frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_r <= 8'd0;
    end else if ((tim_if.hcnt == H_LAST) && (tim_if.vcnt == V_LAST)) begin
      frame_r <= frame_r + 8'd1;
    end else begin
      frame_r <= frame_r;
    end
  end

  assign text_rgb_s = (frame_r[7:2] == 6'd0) ? 6'h3F : frame_r[7:2];
  wire unused_frame_s = &{1'b0, frame_r[1:0]};
`else
  assign text_rgb_s = 6'h3F;
`endif

  // Pixel colour selection; rgb is {R1,R0,G1,G0,B1,B0}.
  always_comb begin
    lit_s     = 1'b0;
    fg_rgb_s  = text_rgb_s;
    bg_rgb_s  = 6'h00;
    pix_rgb_s = 6'h00;
    if (in_box_s && (col_s < 3'd5)) begin
      lit_s = glyph_pad_s[col_s];
    end else begin
      lit_s = 1'b0;
    end
    if (ui_in[0]) begin
      fg_rgb_s = 6'h00;
      bg_rgb_s = text_rgb_s;
    end else begin
      fg_rgb_s = text_rgb_s;
      bg_rgb_s = 6'h00;
    end
    if (!tim_if.visible) begin
      pix_rgb_s = 6'h00;
    end else if (lit_s) begin
      pix_rgb_s = fg_rgb_s;
    end else begin
      pix_rgb_s = bg_rgb_s;
    end
  end

  assign uo_next_s = {tim_if.hsync, pix_rgb_s[0], pix_rgb_s[2], pix_rgb_s[4],
                      tim_if.vsync, pix_rgb_s[1], pix_rgb_s[3], pix_rgb_s[5]};

  // Output register keeps syncs and colour aligned to the same pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uo_r <= 8'h88;
    end else begin
      uo_r <= uo_next_s;
    end
  end

  assign uo_out  = uo_r;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  wire unused_inputs_s = &{1'b0, ena, uio_in, ui_in[7:1], tx_s[9], tx_s[1:0],
                           ty_s[9:5], ty_s[1:0]};

endmodule

// File: tb/tb_tt_um_vga_hello_world.sv
// Directed bench for tt_um_vga_hello_world: reset, sync timing, blanking and text pixels.
module tb_tt_um_vga_hello_world;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n       = 0;

  vga_hello_if probe_if ();

  tt_um_vga_hello_world dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; then update the expected raster position of the pixel now on uo_out.
  task automatic tick();
    int pos;
    @(posedge clk);
    #1;
    edge_n++;
    pos = edge_n - 1;
    probe_if.hcnt    = 10'(pos % 800);
    probe_if.vcnt    = 10'((pos / 800) % 525);
    probe_if.hsync   = !((probe_if.hcnt >= 10'd656) && (probe_if.hcnt < 10'd752));
    probe_if.vsync   = !((probe_if.vcnt >= 10'd490) && (probe_if.vcnt < 10'd492));
    probe_if.visible = (probe_if.hcnt < 10'd640) && (probe_if.vcnt < 10'd480);
  endtask

  task automatic goto_edge(input int target);
    while (edge_n < target) tick();
  endtask

  // Pixel (x,y) is on uo_out after edge y*800+x+1 counted from reset release.
  task automatic check_px(input string tag, input int x, input int y, input logic [7:0] exp);
    goto_edge(y * 800 + x + 1);
    check_eq(tag, {24'd0, uo_out}, {24'd0, exp});
  endtask

  initial begin
    int f1, r1, f2, sync_err, blank_err;
    logic prev;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;
    check_eq("uio_out_pre_reset", {24'd0, uio_out}, 32'd0);
    check_eq("uio_oe_pre_reset", {24'd0, uio_oe}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("reset_uo", {24'd0, uo_out}, 32'h88);
    check_eq("reset_uio_out", {24'd0, uio_out}, 32'd0);
    check_eq("reset_uio_oe", {24'd0, uio_oe}, 32'd0);
    rst_n  = 1'b1;
    edge_n = 0;

    // Line timing over the first two lines.
    f1 = -1; r1 = -1; f2 = -1; sync_err = 0; blank_err = 0; prev = 1'b1;
    while (edge_n < 1700) begin
      tick();
      if ((uo_out[7] !== probe_if.hsync) || (uo_out[3] !== probe_if.vsync)) sync_err++;
      if (!probe_if.visible && ({uo_out[6:4], uo_out[2:0]} !== 6'd0)) blank_err++;
      if (prev && !uo_out[7]) begin
        if (f1 < 0) f1 = edge_n;
        else if (f2 < 0) f2 = edge_n;
      end
      if (!prev && uo_out[7] && (r1 < 0)) r1 = edge_n;
      prev = uo_out[7];
    end
    check_eq("hsync_first_fall", f1, 657);
    check_eq("hsync_low_width", r1 - f1, 96);
    check_eq("hsync_period", f2 - f1, 800);
    check_eq("line_sync_model", sync_err, 0);
    check_eq("hblank_colour", blank_err, 0);

    // Inverted colours on an ordinary line.
    ui_in = 8'h01;
    check_px("inv_background", 100, 100, 8'hFF);
    check_px("inv_hblank", 700, 100, 8'h08);
    ui_in = 8'h00;

    check_px("text_H_col0", 144, 224, 8'hFF);
    check_px("text_H_col1", 148, 224, 8'h88);
    check_px("text_E_col0", 176, 224, 8'hFF);
    ui_in = 8'h01;
    check_px("inv_H_col0", 144, 225, 8'h88);
    check_px("inv_H_col1", 148, 225, 8'hFF);
    ui_in = 8'h00;
    check_px("text_H_col4", 160, 227, 8'hFF);
    check_px("border_left", 143, 230, 8'h88);
    for (int x = 304; x <= 335; x++) check_px("space_cell", x, 230, 8'h88);
    check_px("border_right", 496, 230, 8'h88);
    check_px("text_D_row4", 480, 240, 8'hFF);
    check_px("text_W_col1", 340, 248, 8'hFF);
    check_px("text_W_col2", 344, 248, 8'h88);
    check_px("text_H_row7", 144, 252, 8'h88);
    check_px("vblank_line480", 100, 480, 8'h88);

    // Vertical sync window.
    goto_edge(391900);
    f1 = -1; r1 = -1; sync_err = 0; blank_err = 0; prev = uo_out[3];
    while (edge_n < 393700) begin
      tick();
      if ((uo_out[7] !== probe_if.hsync) || (uo_out[3] !== probe_if.vsync)) sync_err++;
      if ({uo_out[6:4], uo_out[2:0]} !== 6'd0) blank_err++;
      if (prev && !uo_out[3] && (f1 < 0)) f1 = edge_n;
      if (!prev && uo_out[3] && (r1 < 0)) r1 = edge_n;
      prev = uo_out[3];
    end
    check_eq("vsync_first_fall", f1, 392001);
    check_eq("vsync_low_width", r1 - f1, 1600);
    check_eq("frame_sync_model", sync_err, 0);
    check_eq("vblank_colour", blank_err, 0);

    // Mid-frame reset restarts the raster at (0,0).
    rst_n = 1'b0;
    ui_in = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midframe_reset_uo", {24'd0, uo_out}, 32'h88);
    rst_n  = 1'b1;
    edge_n = 0;
    check_px("restart_pixel0_inv", 0, 0, 8'hFF);
    goto_edge(656);
    check_eq("restart_hsync_high", {31'd0, uo_out[7]}, 32'd1);
    goto_edge(657);
    check_eq("restart_hsync_fall", {31'd0, uo_out[7]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
